// File: rtl/quickq_seq_ctrl.sv
// quickq_seq_ctrl: sequencing controller for the QuickQ sorted BRAM min-queue.
// The smallest value is always at index 0. Enqueue carries the new value up
// the array with compare-swaps. Dequeue returns index 0 and then shifts the
// remaining entries down one slot.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   enq, deq, data_in   host requests, sampled only while ready=1
//   ready               idle, accepts a request this cycle
//   data_out, deq_valid last dequeued value, one-cycle update pulse
//   count, full, empty  queue occupancy
//   overflow, underflow one-cycle pulses for rejected requests
//   bram_*              single-port BRAM (read data one cycle after address)
//   head, head_valid    current minimum, only with QUICKQ_PEEK_EN (else 0)
// Optional feature macro: QUICKQ_PEEK_EN
module quickq_seq_ctrl #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enq,
  input  logic          deq,
  input  logic [DW-1:0] data_in,
  output logic          ready,
  output logic [DW-1:0] data_out,
  output logic          deq_valid,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic          overflow,
  output logic          underflow,
  output logic [AW-1:0] bram_addr,
  output logic          bram_we,
  output logic [DW-1:0] bram_wdata,
  input  logic [DW-1:0] bram_rdata,
  output logic [DW-1:0] head,
  output logic          head_valid
);

  localparam int unsigned CW = AW + 1;

  typedef enum logic [3:0] {
    IDLE, ENQ_RD, ENQ_CMP, ENQ_LAST, DEQ_RD, DEQ_CAP, DEQ_SH_RD, DEQ_SH_WR, DONE
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] carry_q, carry_d;
  logic [CW-1:0] i_q, i_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          ready_q, ready_d;
  logic [DW-1:0] data_out_q, data_out_d;
  logic          deq_valid_q, deq_valid_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic [CW-1:0] i_inc;
  logic [CW-1:0] i_dec;
  logic          swap;

  assign i_inc = i_q + CW'(1);
  assign i_dec = i_q - CW'(1);
  // Strict less-than: equal keys never swap, preserving FIFO order among ties.
  assign swap  = (carry_q < bram_rdata);

  // BRAM port decoded from the state registers; a compare step must read,
  // decide and write back within one cycle at the same address.
  always_comb begin
    bram_addr  = '0;
    bram_we    = 1'b0;
    bram_wdata = '0;
    case (state_q)
      ENQ_RD:    bram_addr = i_q[AW-1:0];
      ENQ_CMP: begin
        bram_addr  = i_q[AW-1:0];
        bram_we    = swap;
        bram_wdata = carry_q;
      end
      ENQ_LAST: begin
        bram_addr  = count_q[AW-1:0];
        bram_we    = 1'b1;
        bram_wdata = carry_q;
      end
      DEQ_SH_RD: bram_addr = i_q[AW-1:0];
      DEQ_SH_WR: begin
        bram_addr  = i_dec[AW-1:0];
        bram_we    = 1'b1;
        bram_wdata = bram_rdata;
      end
      default: ;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    carry_d     = carry_q;
    i_d         = i_q;
    count_d     = count_q;
    data_out_d  = data_out_q;
    deq_valid_d = 1'b0;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    case (state_q)
      IDLE: begin
        underflow_d = deq && empty_q;
        if (deq && !empty_q) begin
          state_d = DEQ_RD;
        end else if (enq && !full_q) begin
          carry_d = data_in;
          i_d     = '0;
          state_d = empty_q ? ENQ_LAST : ENQ_RD;
        end else begin
          overflow_d = enq && full_q;
        end
      end
      ENQ_RD:  state_d = ENQ_CMP;
      ENQ_CMP: begin
        if (swap) carry_d = bram_rdata;
        i_d     = i_inc;
        state_d = (i_inc == count_q) ? ENQ_LAST : ENQ_RD;
      end
      ENQ_LAST: begin
        count_d = count_q + CW'(1);
        state_d = DONE;
      end
      DEQ_RD:  state_d = DEQ_CAP;
      DEQ_CAP: begin
        data_out_d = bram_rdata;
        i_d        = CW'(1);
        if (count_q > CW'(1)) begin
          state_d = DEQ_SH_RD;
        end else begin
          count_d     = count_q - CW'(1);
          deq_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DEQ_SH_RD: state_d = DEQ_SH_WR;
      DEQ_SH_WR: begin
        i_d = i_inc;
        if (i_inc < count_q) begin
          state_d = DEQ_SH_RD;
        end else begin
          count_d     = count_q - CW'(1);
          deq_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      carry_q     <= '0;
      i_q         <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      ready_q     <= 1'b1;
      data_out_q  <= '0;
      deq_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      carry_q     <= carry_d;
      i_q         <= i_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      ready_q     <= ready_d;
      data_out_q  <= data_out_d;
      deq_valid_q <= deq_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign ready     = ready_q;
  assign data_out  = data_out_q;
  assign deq_valid = deq_valid_q;
  assign count     = count_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

`ifdef QUICKQ_PEEK_EN
  logic [DW-1:0] head_q, head_d;
  logic          head_valid_q, head_valid_d;

  // Shadow copy of bram[0], tracking every write that lands on index 0.
  always_comb begin
    head_d       = head_q;
    head_valid_d = (count_d != '0);
    if ((state_q == ENQ_CMP || state_q == ENQ_LAST) && bram_we && bram_addr == '0)
      head_d = bram_wdata;
    if (state_q == DEQ_SH_WR && i_q == CW'(1))
      head_d = bram_rdata;
    if (state_q == DEQ_CAP && count_q == CW'(1))
      head_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q       <= '0;
      head_valid_q <= 1'b0;
    end else begin
      head_q       <= head_d;
      head_valid_q <= head_valid_d;
    end
  end

  assign head       = head_q;
  assign head_valid = head_valid_q;
`else
  assign head       = '0;
  assign head_valid = 1'b0;
`endif

endmodule

// File: tb/tb_quickq_seq_ctrl.sv
// Testbench for quickq_seq_ctrl (DEPTH=4) with a behavioural BRAM and a
// reference sorted-queue model feeding a dequeue scoreboard.
module tb_quickq_seq_ctrl;
  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          enq, deq;
  logic [DW-1:0] data_in;
  logic          ready;
  logic [DW-1:0] data_out;
  logic          deq_valid;
  logic [AW:0]   count;
  logic          full, empty, overflow, underflow;
  logic [AW-1:0] bram_addr;
  logic          bram_we;
  logic [DW-1:0] bram_wdata;
  logic [DW-1:0] bram_rdata;
  logic [DW-1:0] head;
  logic          head_valid;

  quickq_seq_ctrl #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .enq(enq), .deq(deq), .data_in(data_in),
    .ready(ready), .data_out(data_out), .deq_valid(deq_valid), .count(count),
    .full(full), .empty(empty), .overflow(overflow), .underflow(underflow),
    .bram_addr(bram_addr), .bram_we(bram_we), .bram_wdata(bram_wdata),
    .bram_rdata(bram_rdata), .head(head), .head_valid(head_valid)
  );

  always #5 clk = ~clk;

  // Single-port read-first BRAM with one-cycle read latency.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bram_we) mem[bram_addr] <= bram_wdata;
    bram_rdata <= mem[bram_addr];
  end

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mdl[$];
  logic [DW-1:0] sb[$];

  typedef struct {
    logic          e;
    logic          d;
    logic [DW-1:0] v;
    int            exp_count;
    logic          exp_ovf;
    logic          exp_unf;
  } vec_t;

  vec_t tv[22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_enq(input logic [DW-1:0] v);
    int k;
    k = 0;
    while (k < mdl.size() && !(v < mdl[k])) k++;
    mdl.insert(k, v);
  endtask

  task automatic run_op(input logic e, input logic d, input logic [DW-1:0] v,
                        output logic ovf, output logic unf);
    int  n, exp_busy, busy, nvalid;
    bit  acc_d, acc_e;
    n        = mdl.size();
    acc_d    = d && n > 0;
    acc_e    = !acc_d && e && n < DEPTH;
    exp_busy = acc_d ? 2*n+1 : (acc_e ? 2*n+2 : 0);
    if (acc_d) sb.push_back(mdl.pop_front());
    if (acc_e) model_enq(v);
    busy   = 0;
    nvalid = 0;
    @(negedge clk);
    check("ready_before_req", 32'(ready), 32'd1);
    enq = e; deq = d; data_in = v;
    @(posedge clk); #1;
    enq = 1'b0; deq = 1'b0;
    ovf = overflow;
    unf = underflow;
    while (!ready && busy < 40) begin
      if (deq_valid) begin
        nvalid++;
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL deq_unexpected: got %0d expected none", data_out);
        end else begin
          check("deq_data", 32'(data_out), 32'(sb.pop_front()));
        end
      end
      busy++;
      @(posedge clk); #1;
    end
    check("busy_cycles", 32'(busy), 32'(exp_busy));
    check("deq_valid_pulses", 32'(nvalid), 32'(acc_d));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic ovf, unf;
    tv[0]  = '{1, 0,  7, 1, 0, 0};
    tv[1]  = '{1, 0,  3, 2, 0, 0};
    tv[2]  = '{1, 0,  9, 3, 0, 0};
    tv[3]  = '{1, 0,  3, 4, 0, 0};
    tv[4]  = '{1, 0,  1, 4, 1, 0};
    tv[5]  = '{0, 1,  0, 3, 0, 0};
    tv[6]  = '{0, 1,  0, 2, 0, 0};
    tv[7]  = '{0, 1,  0, 1, 0, 0};
    tv[8]  = '{0, 1,  0, 0, 0, 0};
    tv[9]  = '{0, 1,  0, 0, 0, 1};
    tv[10] = '{1, 1,  5, 1, 0, 1};
    tv[11] = '{0, 1,  0, 0, 0, 0};
    tv[12] = '{1, 0, 10, 1, 0, 0};
    tv[13] = '{1, 0, 20, 2, 0, 0};
    tv[14] = '{1, 0,  5, 3, 0, 0};
    tv[15] = '{1, 0, 15, 4, 0, 0};
    tv[16] = '{0, 1,  0, 3, 0, 0};
    tv[17] = '{1, 0,  0, 4, 0, 0};
    tv[18] = '{0, 1,  0, 3, 0, 0};
    tv[19] = '{0, 1,  0, 2, 0, 0};
    tv[20] = '{0, 1,  0, 1, 0, 0};
    tv[21] = '{0, 1,  0, 0, 0, 0};

    rst = 1'b1; enq = 1'b0; deq = 1'b0; data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_pulses", {29'd0, deq_valid, overflow, underflow}, 32'd0);
    check("rst_bram", {15'd0, bram_we, 14'(bram_addr), 2'b00} | 32'(bram_wdata), 32'd0);
    check("rst_head", {15'd0, head_valid, head}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 22; i++) begin
      run_op(tv[i].e, tv[i].d, tv[i].v, ovf, unf);
      check($sformatf("v%0d_overflow", i), 32'(ovf), 32'(tv[i].exp_ovf));
      check($sformatf("v%0d_underflow", i), 32'(unf), 32'(tv[i].exp_unf));
      check($sformatf("v%0d_count", i), 32'(count), 32'(tv[i].exp_count));
      check($sformatf("v%0d_full", i), 32'(full), 32'(tv[i].exp_count == DEPTH));
      check($sformatf("v%0d_empty", i), 32'(empty), 32'(tv[i].exp_count == 0));
      if (i == 3 || i == 4) begin
        check("bram0", 32'(mem[0]), 32'd3);
        check("bram1", 32'(mem[1]), 32'd3);
        check("bram2", 32'(mem[2]), 32'd7);
        check("bram3", 32'(mem[3]), 32'd9);
      end
      if (i == 4) begin
        @(posedge clk); #1;
        check("overflow_one_cycle", 32'(overflow), 32'd0);
      end
      if (i == 10) check("bram0_after_both", 32'(mem[0]), 32'd5);
    end

    // Reset while the enqueue walk sits in ENQ_CMP.
    run_op(1'b1, 1'b0, 16'd4, ovf, unf);
    run_op(1'b1, 1'b0, 16'd6, ovf, unf);
    @(negedge clk);
    enq = 1'b1; data_in = 16'd5;
    @(posedge clk); #1;
    enq = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_ready", 32'(ready), 32'd1);
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_empty", 32'(empty), 32'd1);
    mdl.delete();
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    run_op(1'b1, 1'b0, 16'd2, ovf, unf);
    check("midrst_bram0", 32'(mem[0]), 32'd2);
    check("midrst_count_after", 32'(count), 32'd1);
    run_op(1'b0, 1'b1, 16'd0, ovf, unf);

    run_op(1'b1, 1'b0, 16'd8, ovf, unf);
`ifdef QUICKQ_PEEK_EN
    check("peek_head_8", 32'(head), 32'd8);
    check("peek_valid_1", 32'(head_valid), 32'd1);
    run_op(1'b1, 1'b0, 16'd4, ovf, unf);
    check("peek_head_4", 32'(head), 32'd4);
    run_op(1'b0, 1'b1, 16'd0, ovf, unf);
    check("peek_head_back_8", 32'(head), 32'd8);
    run_op(1'b0, 1'b1, 16'd0, ovf, unf);
    check("peek_valid_0", 32'(head_valid), 32'd0);
    check("peek_head_0", 32'(head), 32'd0);
`else
    check("nopeek_head", 32'(head), 32'd0);
    check("nopeek_valid", 32'(head_valid), 32'd0);
    run_op(1'b0, 1'b1, 16'd0, ovf, unf);
`endif

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
